// File: rtl/canon_pkg.sv
// Shared constants and types for the canon demo timebase.
package canon_pkg;

   localparam int unsigned CROTCHET_W            = 7;
   localparam int unsigned CROTCHETS_PER_PHRASE  = 8;
   localparam int unsigned NUM_CROTCHETS_DEFAULT = 104;

   typedef enum logic [1:0] {IDLE, PLAYING, PAUSED, FINISHED} seq_state_t;

endpackage

// File: rtl/beat_sequencer_if.sv
// Run control in, crotchet/quaver timebase out, between the tempo master and its consumers.
interface beat_sequencer_if;
   import canon_pkg::*;

   logic                  run;
   logic                  restart;
   logic [CROTCHET_W-1:0] crotchet;
   logic                  crotchet_pulse;
   logic                  quaver_pulse;
   logic                  quaver_phase;
   logic                  playing;
   logic                  done;

   modport master (
      output run, restart,
      input  crotchet, crotchet_pulse, quaver_pulse, quaver_phase, playing, done
   );

   modport slave (
      input  run, restart,
      output crotchet, crotchet_pulse, quaver_pulse, quaver_phase, playing, done
   );

endinterface

// File: rtl/beat_sequencer_tick_divider.sv
// Free-running modulo-CYCLES counter; tick marks the enabled terminal-count cycle.
module tick_divider #(
   parameter int unsigned CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [W-1:0] LAST = W'(CYCLES - 1);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = (count_q == LAST) ? '0 : count_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Clear always wins so a restart on terminal count produces no event.
   assign tick = enable && !clear && (count_q == LAST);

endmodule

// File: rtl/beat_sequencer.sv
// Tempo master: steps a crotchet index at two quavers per crotchet, with run/pause/restart.
module beat_sequencer
   import canon_pkg::*;
#(
   parameter int unsigned CLOCKS_PER_QUAVER = 10_920_000,
   parameter int unsigned NUM_CROTCHETS     = NUM_CROTCHETS_DEFAULT,
   parameter bit          LOOP              = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   beat_sequencer_if.slave   bus
);

   localparam logic [CROTCHET_W-1:0] LAST_CROTCHET = CROTCHET_W'(NUM_CROTCHETS - 1);

   seq_state_t            state_q, state_d;
   logic [CROTCHET_W-1:0] crotchet_q, crotchet_d;
   logic                  phase_q, phase_d;
   logic                  cpulse_q, cpulse_d;
   logic                  qpulse_q, qpulse_d;
   logic                  playing_q, done_q;
   logic                  div_clear, div_en, tick;

   // Resuming from PAUSED counts on the same edge that run is seen high.
   assign div_clear = bus.restart || (state_q == IDLE);
   assign div_en    = bus.run && ((state_q == PLAYING) || (state_q == PAUSED));

   tick_divider #(
      .CYCLES (CLOCKS_PER_QUAVER)
   ) u_tick_divider (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (div_clear),
      .enable (div_en),
      .tick   (tick)
   );

   always_comb begin
      state_d    = state_q;
      crotchet_d = crotchet_q;
      phase_d    = phase_q;
      cpulse_d   = 1'b0;
      qpulse_d   = 1'b0;
      if (bus.restart) begin
         state_d    = IDLE;
         crotchet_d = '0;
         phase_d    = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.run) begin
                  state_d    = PLAYING;
                  crotchet_d = '0;
                  phase_d    = 1'b0;
                  cpulse_d   = 1'b1;
                  qpulse_d   = 1'b1;
               end
            end
            PLAYING, PAUSED: begin
               if (!bus.run) begin
                  state_d = PAUSED;
               end else begin
                  state_d = PLAYING;
                  if (tick && !phase_q) begin
                     phase_d  = 1'b1;
                     qpulse_d = 1'b1;
                  end else if (tick) begin
                     phase_d = 1'b0;
                     if (crotchet_q < LAST_CROTCHET) begin
                        crotchet_d = crotchet_q + CROTCHET_W'(1);
                        cpulse_d   = 1'b1;
                        qpulse_d   = 1'b1;
                     end else if (LOOP) begin
                        crotchet_d = '0;
                        cpulse_d   = 1'b1;
                        qpulse_d   = 1'b1;
                     end else begin
                        state_d = FINISHED;
                     end
                  end
               end
            end
            FINISHED: begin
               state_d = FINISHED;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         crotchet_q <= '0;
         phase_q    <= 1'b0;
         cpulse_q   <= 1'b0;
         qpulse_q   <= 1'b0;
         playing_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         crotchet_q <= crotchet_d;
         phase_q    <= phase_d;
         cpulse_q   <= cpulse_d;
         qpulse_q   <= qpulse_d;
         playing_q  <= (state_d == PLAYING);
         done_q     <= (state_d == FINISHED);
      end
   end

   assign bus.crotchet       = crotchet_q;
   assign bus.crotchet_pulse = cpulse_q;
   assign bus.quaver_pulse   = qpulse_q;
   assign bus.quaver_phase   = phase_q;
   assign bus.playing        = playing_q;
   assign bus.done           = done_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Bench for beat_sequencer: looping and non-looping instances against an elapsed-time model.
module tb_beat_sequencer;
   import canon_pkg::*;

   localparam int unsigned CQ = 4;
   localparam int unsigned NC = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   beat_sequencer_if bus_l ();
   beat_sequencer_if bus_s ();

   beat_sequencer #(
      .CLOCKS_PER_QUAVER (CQ),
      .NUM_CROTCHETS     (NC),
      .LOOP              (1'b1)
   ) dut_l (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_l)
   );

   beat_sequencer #(
      .CLOCKS_PER_QUAVER (CQ),
      .NUM_CROTCHETS     (NC),
      .LOOP              (1'b0)
   ) dut_s (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_s)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Model: time elapsed while running since the first beat decides everything.
   // Output vector: {crotchet[6:0], crotchet_pulse, quaver_pulse, quaver_phase, playing, done}
   bit          m_started[2];
   bit          m_fin[2];
   int          m_t[2];
   logic [11:0] exp_o[2];

   function automatic logic [11:0] dut_out(input int i);
      if (i == 0)
         return {bus_l.crotchet, bus_l.crotchet_pulse, bus_l.quaver_pulse,
                 bus_l.quaver_phase, bus_l.playing, bus_l.done};
      return {bus_s.crotchet, bus_s.crotchet_pulse, bus_s.quaver_pulse,
              bus_s.quaver_phase, bus_s.playing, bus_s.done};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_started[i] = 1'b0;
         m_fin[i]     = 1'b0;
         m_t[i]       = 0;
         exp_o[i]     = '0;
      end
   endtask

   task automatic model_edge(input int i, input bit run, input bit rs, input bit loop);
      int  b;
      bit  cp, qp, ph;
      if (rs) begin
         m_started[i] = 1'b0;
         m_fin[i]     = 1'b0;
         m_t[i]       = 0;
         exp_o[i]     = '0;
      end else if (!m_started[i]) begin
         if (run) begin
            m_started[i] = 1'b1;
            m_t[i]       = 0;
            exp_o[i]     = {7'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
         end else begin
            exp_o[i] = '0;
         end
      end else if (m_fin[i]) begin
         exp_o[i] = {7'(NC - 1), 5'b00001};
      end else if (!run) begin
         exp_o[i][4] = 1'b0;
         exp_o[i][3] = 1'b0;
         exp_o[i][1] = 1'b0;
      end else begin
         m_t[i] = m_t[i] + 1;
         b  = m_t[i] / (2 * CQ);
         qp = (m_t[i] % CQ) == 0;
         cp = (m_t[i] % (2 * CQ)) == 0;
         ph = ((m_t[i] / CQ) % 2) == 1;
         if (!loop && b >= NC) begin
            m_fin[i] = 1'b1;
            exp_o[i] = {7'(NC - 1), 5'b00001};
         end else begin
            exp_o[i] = {7'(b % NC), cp, qp, ph, 1'b1, 1'b0};
         end
      end
   endtask

   task automatic step(input bit run, input bit rs);
      bus_l.run     = run;
      bus_l.restart = rs;
      bus_s.run     = run;
      bus_s.restart = rs;
      @(posedge clk);
      #1;
      cyc++;
      model_edge(0, run, rs, 1'b1);
      model_edge(1, run, rs, 1'b0);
   endtask

   task automatic test_reset();
      logic [11:0] got;
      bus_l.run = 1'b0; bus_l.restart = 1'b0;
      bus_s.run = 1'b0; bus_s.restart = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) step(1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         got = dut_out(i);
         checks++;
         if (got !== 12'h000) begin
            errors++;
            $display("FAIL reset_idle dut%0d: got %h expected %h", i, got, 12'h000);
         end
      end
      repeat (7) step(1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         got = dut_out(i);
         checks++;
         if (got !== 12'h000) begin
            errors++;
            $display("FAIL reset_async dut%0d: got %h expected %h", i, got, 12'h000);
         end
      end
      bus_l.run = 1'b0;
      bus_s.run = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      repeat (3) begin
         step(1'b0, 1'b0);
         for (int i = 0; i < 2; i++) begin
            got = dut_out(i);
            checks++;
            if (got !== exp_o[i]) begin
               errors++;
               $display("FAIL reset_release dut%0d: got %h expected %h", i, got, exp_o[i]);
            end
         end
      end
   endtask

   task automatic test_cadence();
      logic [11:0] got, want;
      for (int k = 1; k <= 20; k++) begin
         step(1'b1, 1'b0);
         for (int i = 0; i < 2; i++) begin
            got = dut_out(i);
            checks++;
            if (got !== exp_o[i]) begin
               errors++;
               $display("FAIL cadence dut%0d edge %0d: got %h expected %h", i, k, got, exp_o[i]);
            end
         end
         if (k == 1 || k == 5 || k == 9 || k == 17) begin
            case (k)
               1:       want = {7'd0, 5'b11010};
               5:       want = {7'd0, 5'b01110};
               9:       want = {7'd1, 5'b11010};
               default: want = {7'd2, 5'b11010};
            endcase
            got = dut_out(0);
            checks++;
            if (got !== want) begin
               errors++;
               $display("FAIL cadence_fixed edge %0d: got %h expected %h", k, got, want);
            end
         end
      end
   endtask

   task automatic test_loop();
      logic [11:0] got;
      for (int k = 21; k <= 25; k++) begin
         step(1'b1, 1'b0);
         got = dut_out(0);
         checks++;
         if (got !== exp_o[0] || got[0] !== 1'b0) begin
            errors++;
            $display("FAIL loop edge %0d: got %h expected %h", k, got, exp_o[0]);
         end
      end
      got = dut_out(0);
      checks++;
      if (got !== {7'd0, 5'b11010}) begin
         errors++;
         $display("FAIL loop_wrap: got %h expected %h", got, {7'd0, 5'b11010});
      end
   endtask

   task automatic test_finish();
      logic [11:0] got;
      got = dut_out(1);
      checks++;
      if (got !== {7'd2, 5'b00001}) begin
         errors++;
         $display("FAIL finish_boundary: got %h expected %h", got, {7'd2, 5'b00001});
      end
      repeat (6) begin
         step(1'b1, 1'b0);
         got = dut_out(1);
         checks++;
         if (got !== exp_o[1]) begin
            errors++;
            $display("FAIL finish_hold: got %h expected %h", got, exp_o[1]);
         end
      end
      step(1'b1, 1'b1);
      got = dut_out(1);
      checks++;
      if (got !== 12'h000) begin
         errors++;
         $display("FAIL finish_restart: got %h expected %h", got, 12'h000);
      end
      step(1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         got = dut_out(i);
         checks++;
         if (got !== {7'd0, 5'b11010} || got !== exp_o[i]) begin
            errors++;
            $display("FAIL finish_first_beat dut%0d: got %h expected %h", i, got, exp_o[i]);
         end
      end
   endtask

   task automatic test_pause();
      logic [11:0] got;
      int beat_edge, n;
      beat_edge = cyc;
      repeat (2) step(1'b1, 1'b0);
      repeat (10) begin
         step(1'b0, 1'b0);
         got = dut_out(0);
         checks++;
         if ({got[4], got[3], got[1]} !== 3'b000 || got !== exp_o[0]) begin
            errors++;
            $display("FAIL pause_quiet: got %h expected %h", got, exp_o[0]);
         end
      end
      n = 0;
      do begin
         step(1'b1, 1'b0);
         n++;
      end while (bus_l.quaver_pulse !== 1'b1 && n < 8);
      checks++;
      if (n != 2) begin
         errors++;
         $display("FAIL pause_resume_latency: got %0d expected %0d", n, 2);
      end
      n = 0;
      while (bus_l.crotchet_pulse !== 1'b1 && n < 20) begin
         step(1'b1, 1'b0);
         n++;
      end
      checks++;
      if (cyc - beat_edge != 2 * CQ + 10) begin
         errors++;
         $display("FAIL pause_period: got %0d expected %0d", cyc - beat_edge, 2 * CQ + 10);
      end
      got = dut_out(0);
      checks++;
      if (got !== exp_o[0]) begin
         errors++;
         $display("FAIL pause_model: got %h expected %h", got, exp_o[0]);
      end
   endtask

   task automatic test_restart_collision();
      logic [11:0] got;
      int n;
      n = 0;
      while (m_t[0] != 11 && n < 16) begin
         step(1'b1, 1'b0);
         n++;
      end
      got = dut_out(0);
      checks++;
      if (got[11:5] !== 7'd1 || m_t[0] != 11) begin
         errors++;
         $display("FAIL collision_setup: got crotchet %0d expected %0d", got[11:5], 1);
      end
      step(1'b1, 1'b1);
      for (int i = 0; i < 2; i++) begin
         got = dut_out(i);
         checks++;
         if (got !== 12'h000) begin
            errors++;
            $display("FAIL collision_restart dut%0d: got %h expected %h", i, got, 12'h000);
         end
      end
      step(1'b1, 1'b0);
      got = dut_out(0);
      checks++;
      if (got !== {7'd0, 5'b11010}) begin
         errors++;
         $display("FAIL collision_first_beat: got %h expected %h", got, {7'd0, 5'b11010});
      end
   endtask

   task automatic test_random();
      logic [11:0] got;
      bit r, rs;
      for (int k = 0; k < 600; k++) begin
         r  = ($urandom_range(0, 99) < 80);
         rs = ($urandom_range(0, 99) < 2);
         step(r, rs);
         for (int i = 0; i < 2; i++) begin
            got = dut_out(i);
            checks++;
            if (got !== exp_o[i]) begin
               errors++;
               $display("FAIL random dut%0d cycle %0d: got %h expected %h", i, cyc, got, exp_o[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_cadence();
      test_loop();
      test_finish();
      test_pause();
      test_restart_collision();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
